// File: rtl/gpr_scoreboard_rf_pkg.sv
// rtl/gpr_scoreboard_rf_pkg.sv - shared sizes and types for the GPR file
// Purpose: register width, register count, index width, index/word types
// and the hardwired-zero register index used by the register file slice.
package npc_rf_pkg;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/gpr_scoreboard_rf_if.sv
// rtl/gpr_scoreboard_rf_if.sv - decode/writeback/debug bundle of the GPR file
// Purpose: groups every non-clock, non-reset signal of gpr_scoreboard_rf.
// Ports (signals): rs1/rs2 addr->data/busy read ports, issue_valid/issue_rd,
// wb_valid/wb_rd/wb_data, flush, sb_err, dbg_regs, dbg_commit,
// dbg_commit_rd, dbg_commit_cnt.
// master = pipeline side (drives requests), slave = register file.
interface gpr_scoreboard_rf_if;
    import npc_rf_pkg::*;

    reg_idx_t                 rs1_addr;
    reg_idx_t                 rs2_addr;
    xword_t                   rs1_data;
    xword_t                   rs2_data;
    logic                     rs1_busy;
    logic                     rs2_busy;
    logic                     issue_valid;
    reg_idx_t                 issue_rd;
    logic                     wb_valid;
    reg_idx_t                 wb_rd;
    xword_t                   wb_data;
    logic                     flush;
    logic                     sb_err;
    logic [NREG*XLEN-1:0]     dbg_regs;
    logic                     dbg_commit;
    reg_idx_t                 dbg_commit_rd;
    logic [63:0]              dbg_commit_cnt;

    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd,
               wb_valid, wb_rd, wb_data, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, sb_err,
               dbg_regs, dbg_commit, dbg_commit_rd, dbg_commit_cnt
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd,
               wb_valid, wb_rd, wb_data, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, sb_err,
               dbg_regs, dbg_commit, dbg_commit_rd, dbg_commit_cnt
    );
endinterface

// File: rtl/gpr_scoreboard_rf_scoreboard.sv
// rtl/gpr_scoreboard_rf_scoreboard.sv - busy-bit scoreboard for the GPR file
// Purpose: tracks one outstanding producer per GPR and flags double issue.
// Ports: clock, reset (sync, high); issue_valid/issue_rd; wb_valid/wb_rd;
// flush; busy[NREG-1:0] out; sb_err out (sticky until reset).
module gpr_scoreboard
    import npc_rf_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rd,
    input  logic            wb_valid,
    input  reg_idx_t        wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic            sb_err
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            err_set;

    // Priority flush > issue > wb: a same-cycle issue and wb to one rd leaves
    // the newer producer outstanding.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (flush)
                busy_d[r] = 1'b0;
            else if (issue_valid && issue_rd == reg_idx_t'(r))
                busy_d[r] = 1'b1;
            else if (wb_valid && wb_rd == reg_idx_t'(r))
                busy_d[r] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // A wb retiring the old producer in the same cycle makes the reissue legal.
    assign err_set = issue_valid && (issue_rd != ZERO_REG) && busy_q[issue_rd]
                     && !(wb_valid && wb_rd == issue_rd) && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
            sb_err <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (err_set)
                sb_err <= 1'b1;
        end
    end

    assign busy = busy_q;
endmodule

// File: rtl/gpr_scoreboard_rf.sv
// rtl/gpr_scoreboard_rf.sv - 32 x XLEN integer register file with scoreboard
// Purpose: 2 bypassed combinational read ports, 1 write port, RAW busy
// status, flattened register export and commit strobe/counter for difftest.
// Ports: clock, reset (sync, high); bus (gpr_scoreboard_rf_if.slave) carrying
// read ports, issue, writeback, flush, sb_err and dbg_* outputs.
module gpr_scoreboard_rf
    import npc_rf_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    gpr_scoreboard_rf_if.slave    bus
);
    xword_t               regs_q [NREG];
    logic [NREG-1:0]      busy;
    logic                 wb_accept;
    logic [NREG*XLEN-1:0] regs_flat;

    // Writes to x0 are dropped entirely: no state change, no commit.
    assign wb_accept = bus.wb_valid && (bus.wb_rd != ZERO_REG);

    gpr_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .wb_valid    (bus.wb_valid),
        .wb_rd       (bus.wb_rd),
        .flush       (bus.flush),
        .busy        (busy),
        .sb_err      (bus.sb_err)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            bus.dbg_commit     <= 1'b0;
            bus.dbg_commit_rd  <= '0;
            bus.dbg_commit_cnt <= '0;
        end else begin
            if (wb_accept)
                regs_q[bus.wb_rd] <= bus.wb_data;
            bus.dbg_commit    <= wb_accept;
            bus.dbg_commit_rd <= wb_accept ? bus.wb_rd : '0;
            if (wb_accept)
                bus.dbg_commit_cnt <= bus.dbg_commit_cnt + 64'd1;
        end
    end

    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_addr == ZERO_REG)
            bus.rs1_data = '0;
        else if (bus.wb_valid && bus.wb_rd == bus.rs1_addr)
            bus.rs1_data = bus.wb_data;
        else
            bus.rs1_data = regs_q[bus.rs1_addr];
    end

    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_addr == ZERO_REG)
            bus.rs2_data = '0;
        else if (bus.wb_valid && bus.wb_rd == bus.rs2_addr)
            bus.rs2_data = bus.wb_data;
        else
            bus.rs2_data = regs_q[bus.rs2_addr];
    end

    // A producer writing back this cycle no longer blocks its consumer.
    assign bus.rs1_busy = busy[bus.rs1_addr] & ~(bus.wb_valid && bus.wb_rd == bus.rs1_addr);
    assign bus.rs2_busy = busy[bus.rs2_addr] & ~(bus.wb_valid && bus.wb_rd == bus.rs2_addr);

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*XLEN +: XLEN] = regs_q[g];
    end
    assign bus.dbg_regs = regs_flat;
endmodule

// File: tb/tb_gpr_scoreboard_rf.sv
// tb/tb_gpr_scoreboard_rf.sv - directed self-checking bench for gpr_scoreboard_rf
module tb_gpr_scoreboard_rf;
    import npc_rf_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    gpr_scoreboard_rf_if bus ();

    gpr_scoreboard_rf dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic drive_idle();
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            bus.rs1_addr = reg_idx_t'(i);
            #1;
            n_checks++;
            if (bus.rs1_data !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_read x%0d: got %h want 0", i, bus.rs1_data);
            end
        end
        n_checks++;
        if (bus.dbg_commit_cnt !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d want 0", bus.dbg_commit_cnt);
        end
        n_checks++;
        if (bus.sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sb_err: got %b want 0", bus.sb_err);
        end
        n_checks++;
        if (bus.dbg_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_commit: got %b want 0", bus.dbg_commit);
        end
    endtask

    task automatic test_write_bypass();
        @(negedge clock);
        drive_idle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 64'hDEAD_BEEF_0000_0001;
        bus.rs1_addr = 5'd5;
        #1;
        n_checks++;
        if (bus.rs1_data !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL bypass_rs1: got %h want deadbeef00000001", bus.rs1_data);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.dbg_commit !== 1'b1 || bus.dbg_commit_rd !== 5'd5) begin
            n_fail++;
            $display("FAIL commit_pulse: got %b/%0d want 1/5", bus.dbg_commit, bus.dbg_commit_rd);
        end
        n_checks++;
        if (bus.dbg_commit_cnt !== 64'd1) begin
            n_fail++;
            $display("FAIL commit_cnt1: got %0d want 1", bus.dbg_commit_cnt);
        end
        n_checks++;
        if (bus.dbg_regs[5*64 +: 64] !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL dbg_regs_x5: got %h want deadbeef00000001", bus.dbg_regs[5*64 +: 64]);
        end
        @(negedge clock);
        drive_idle();
        bus.rs2_addr = 5'd5;
        #1;
        n_checks++;
        if (bus.rs2_data !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL array_read_x5: got %h want deadbeef00000001", bus.rs2_data);
        end
    endtask

    task automatic test_x0_write();
        @(negedge clock);
        drive_idle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 64'h1234;
        bus.rs1_addr = 5'd0;
        #1;
        n_checks++;
        if (bus.rs1_data !== 64'd0) begin
            n_fail++;
            $display("FAIL x0_bypass: got %h want 0", bus.rs1_data);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.dbg_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_commit: got %b want 0", bus.dbg_commit);
        end
        n_checks++;
        if (bus.dbg_commit_cnt !== 64'd1) begin
            n_fail++;
            $display("FAIL x0_cnt: got %0d want 1", bus.dbg_commit_cnt);
        end
        n_checks++;
        if (bus.dbg_regs[63:0] !== 64'd0) begin
            n_fail++;
            $display("FAIL x0_dbg: got %h want 0", bus.dbg_regs[63:0]);
        end
    endtask

    task automatic test_busy();
        @(negedge clock);
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        @(negedge clock);
        drive_idle();
        bus.rs2_addr = 5'd7;
        #1;
        n_checks++;
        if (bus.rs2_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_issue: got %b want 1", bus.rs2_busy);
        end
        @(negedge clock);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd7;
        bus.wb_data  = 64'h77;
        #1;
        n_checks++;
        if (bus.rs2_busy !== 1'b0 || bus.rs2_data !== 64'h77) begin
            n_fail++;
            $display("FAIL busy_wb_same_cycle: got %b/%h want 0/77", bus.rs2_busy, bus.rs2_data);
        end
        @(negedge clock);
        drive_idle();
        bus.rs2_addr = 5'd7;
        #1;
        n_checks++;
        if (bus.rs2_busy !== 1'b0 || bus.dbg_commit_cnt !== 64'd2) begin
            n_fail++;
            $display("FAIL busy_cleared: got %b/%0d want 0/2", bus.rs2_busy, bus.dbg_commit_cnt);
        end
    endtask

    task automatic test_same_cycle_issue_wb();
        @(negedge clock);
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd9;
        bus.wb_data     = 64'h99;
        @(negedge clock);
        drive_idle();
        bus.rs1_addr = 5'd9;
        #1;
        n_checks++;
        if (bus.rs1_busy !== 1'b1 || bus.rs1_data !== 64'h99) begin
            n_fail++;
            $display("FAIL issue_wb_same: got %b/%h want 1/99", bus.rs1_busy, bus.rs1_data);
        end
        n_checks++;
        if (bus.sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_err_early: got %b want 0", bus.sb_err);
        end
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        @(negedge clock);
        drive_idle();
        #1;
        n_checks++;
        if (bus.sb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_err_set: got %b want 1", bus.sb_err);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.sb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_err_sticky: got %b want 1", bus.sb_err);
        end
    endtask

    task automatic test_flush();
        @(negedge clock);
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        @(negedge clock);
        bus.issue_rd    = 5'd4;
        @(negedge clock);
        drive_idle();
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd4;
        #1;
        n_checks++;
        if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_flush_busy: got %b/%b want 1/1", bus.rs1_busy, bus.rs2_busy);
        end
        bus.flush       = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd10;
        bus.wb_data     = 64'hAA;
        @(negedge clock);
        drive_idle();
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd4;
        #1;
        n_checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy_3_4: got %b/%b want 0/0", bus.rs1_busy, bus.rs2_busy);
        end
        bus.rs1_addr = 5'd6;
        bus.rs2_addr = 5'd9;
        #1;
        n_checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy_6_9: got %b/%b want 0/0", bus.rs1_busy, bus.rs2_busy);
        end
        bus.rs1_addr = 5'd10;
        #1;
        n_checks++;
        if (bus.rs1_data !== 64'hAA || bus.dbg_commit_cnt !== 64'd4) begin
            n_fail++;
            $display("FAIL flush_wb: got %h/%0d want aa/4", bus.rs1_data, bus.dbg_commit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            drive_idle();
            bus.wb_valid = 1'b1;
            bus.wb_rd    = reg_idx_t'(i + 10);
            bus.wb_data  = 64'h1000 + 64'(i);
            @(posedge clock);
            #1;
            n_checks++;
            if (bus.dbg_commit !== 1'b1 || bus.dbg_commit_rd !== reg_idx_t'(i + 10)
                || bus.dbg_commit_cnt !== 64'(4 + i)) begin
                n_fail++;
                $display("FAIL b2b_commit_%0d: got %b/%0d/%0d want 1/%0d/%0d", i,
                         bus.dbg_commit, bus.dbg_commit_rd, bus.dbg_commit_cnt, i + 10, 4 + i);
            end
        end
        @(negedge clock);
        drive_idle();
        for (int i = 1; i <= 4; i++) begin
            bus.rs2_addr = reg_idx_t'(i + 10);
            #1;
            n_checks++;
            if (bus.rs2_data !== 64'h1000 + 64'(i)) begin
                n_fail++;
                $display("FAIL b2b_read_%0d: got %h want %h", i, bus.rs2_data, 64'h1000 + 64'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd12;
        @(negedge clock);
        drive_idle();
        reset        = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd20;
        bus.wb_data  = 64'h5555;
        @(negedge clock);
        reset = 1'b0;
        drive_idle();
        #1;
        for (int i = 0; i < NREG; i++) begin
            n_checks++;
            if (bus.dbg_regs[i*64 +: 64] !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_mid_x%0d: got %h want 0", i, bus.dbg_regs[i*64 +: 64]);
            end
        end
        n_checks++;
        if (bus.dbg_commit_cnt !== 64'd0 || bus.dbg_commit !== 1'b0 || bus.sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_dbg: got cnt %0d commit %b err %b want 0/0/0",
                     bus.dbg_commit_cnt, bus.dbg_commit, bus.sb_err);
        end
        bus.rs1_addr = 5'd12;
        #1;
        n_checks++;
        if (bus.rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %b want 0", bus.rs1_busy);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_write_bypass();
        test_x0_write();
        test_busy();
        test_same_cycle_issue_wb();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
